// File: rtl/oled_rect_fill.sv
// oled_rect_fill
//   Rectangle-fill engine. Accepts an RGB565 colour and an inclusive pixel
//   rectangle through a valid/ready handshake, expands the colour to RGB888
//   and issues one OLED pixel write per pixel, row-major, every PACE cycles.
//
// Parameters
//   COLS  display width  (1..128)
//   ROWS  display height (1..64)
//   PACE  cycles between consecutive pixel writes (>=1)
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_color                  RGB565 colour
//   req_x0/req_x1, req_y0/req_y1  inclusive bounds, upper bounds clamped
//   OLED_Write                 one-cycle pixel write strobe
//   OLED_Col/OLED_Row/OLED_Data pixel address and RGB888 data, held between writes
//   busy                       high while filling and in the completion cycle
//   done                       one-cycle completion pulse
module oled_rect_fill #(
  parameter int COLS = 96,
  parameter int ROWS = 64,
  parameter int PACE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_color,
  input  logic [6:0]  req_x0,
  input  logic [6:0]  req_x1,
  input  logic [5:0]  req_y0,
  input  logic [5:0]  req_y1,
  output logic        OLED_Write,
  output logic [6:0]  OLED_Col,
  output logic [5:0]  OLED_Row,
  output logic [23:0] OLED_Data,
  output logic        busy,
  output logic        done
);

  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [6:0]    COL_MAX     = 7'(COLS - 1);
  localparam logic [5:0]    ROW_MAX     = 6'(ROWS - 1);
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      x0_q, x0_d;
  logic [6:0]      x1c_q, x1c_d;
  logic [5:0]      y1c_q, y1c_d;
  logic [PW-1:0]   pace_q, pace_d;
  logic            write_q, write_d;
  logic [6:0]      col_q, col_d;
  logic [5:0]      row_q, row_d;
  logic [23:0]     data_q, data_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [6:0]      x1c;
  logic [5:0]      y1c;
  logic            empty_rect;
  logic [23:0]     color888;

  // Request decode: clamp the upper bounds, detect an empty rectangle and
  // expand RGB565 to RGB888 by replicating the top bits into the low bits.
  always_comb begin
    x1c        = (req_x1 > COL_MAX) ? COL_MAX : req_x1;
    y1c        = (req_y1 > ROW_MAX) ? ROW_MAX : req_y1;
    empty_rect = (req_x0 > x1c) || (req_y0 > y1c);
    color888   = {req_color[15:11], req_color[15:13],
                  req_color[10:5],  req_color[10:9],
                  req_color[4:0],   req_color[4:2]};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1c_d   = x1c_q;
    y1c_d   = y1c_q;
    pace_d  = pace_q;
    write_d = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          x0_d  = req_x0;
          x1c_d = x1c;
          y1c_d = y1c;
          if (empty_rect) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // First pixel is written straight out of the acceptance edge.
            state_d = FILL;
            write_d = 1'b1;
            col_d   = req_x0;
            row_d   = req_y0;
            data_d  = color888;
            pace_d  = PACE_RELOAD;
          end
        end
      end
      FILL: begin
        // Position registers only reach (x1c,y1c) on the final write, so the
        // completion pulse follows that write by exactly one cycle.
        if ((col_q == x1c_q) && (row_q == y1c_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (pace_q != {PW{1'b0}}) begin
          pace_d = pace_q - PW'(1);
        end else begin
          write_d = 1'b1;
          pace_d  = PACE_RELOAD;
          if (col_q == x1c_q) begin
            col_d = x0_q;
            row_d = row_q + 6'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      x0_q    <= 7'd0;
      x1c_q   <= 7'd0;
      y1c_q   <= 6'd0;
      pace_q  <= {PW{1'b0}};
      write_q <= 1'b0;
      col_q   <= 7'd0;
      row_q   <= 6'd0;
      data_q  <= 24'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1c_q   <= x1c_d;
      y1c_q   <= y1c_d;
      pace_q  <= pace_d;
      write_q <= write_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready  = ready_q;
  assign OLED_Write = write_q;
  assign OLED_Col   = col_q;
  assign OLED_Row   = row_q;
  assign OLED_Data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_oled_rect_fill.sv
// Directed bench for oled_rect_fill. Two instances share clock and reset:
// one with PACE=1, one with PACE=3; 'sel' picks which one is driven/observed.
module tb_oled_rect_fill;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        sel;
  logic        req_valid;
  logic [15:0] req_color;
  logic [6:0]  req_x0, req_x1;
  logic [5:0]  req_y0, req_y1;

  logic        a_ready, a_write, a_busy, a_done;
  logic [6:0]  a_col;
  logic [5:0]  a_row;
  logic [23:0] a_data;
  logic        b_ready, b_write, b_busy, b_done;
  logic [6:0]  b_col;
  logic [5:0]  b_row;
  logic [23:0] b_data;

  logic        o_ready, o_write, o_busy, o_done;
  logic [6:0]  o_col;
  logic [5:0]  o_row;
  logic [23:0] o_data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  oled_rect_fill #(.COLS(96), .ROWS(64), .PACE(1)) u_dut_p1 (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_color(req_color), .req_x0(req_x0), .req_x1(req_x1),
    .req_y0(req_y0), .req_y1(req_y1), .OLED_Write(a_write), .OLED_Col(a_col),
    .OLED_Row(a_row), .OLED_Data(a_data), .busy(a_busy), .done(a_done));

  oled_rect_fill #(.COLS(96), .ROWS(64), .PACE(3)) u_dut_p3 (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_color(req_color), .req_x0(req_x0), .req_x1(req_x1),
    .req_y0(req_y0), .req_y1(req_y1), .OLED_Write(b_write), .OLED_Col(b_col),
    .OLED_Row(b_row), .OLED_Data(b_data), .busy(b_busy), .done(b_done));

  assign o_ready = sel ? b_ready : a_ready;
  assign o_write = sel ? b_write : a_write;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_col   = sel ? b_col   : a_col;
  assign o_row   = sel ? b_row   : a_row;
  assign o_data  = sel ? b_data  : a_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ready"}, {31'd0, o_ready}, 32'd0);
    check_eq({tag, " write"}, {31'd0, o_write}, 32'd0);
    check_eq({tag, " busy"},  {31'd0, o_busy},  32'd0);
    check_eq({tag, " done"},  {31'd0, o_done},  32'd0);
    check_eq({tag, " col"},   {25'd0, o_col},   32'd0);
    check_eq({tag, " row"},   {26'd0, o_row},   32'd0);
    check_eq({tag, " data"},  {8'd0, o_data},   32'd0);
  endtask

  // Issue one request and check every cycle until ready returns.
  // hold: keep req_valid high and scramble req_color during the fill.
  // abort_c: cycle in which RESET is raised (0 = never).
  task automatic run_fill(input logic use3, input int pace,
                          input int x0, input int x1, input int y0, input int y1,
                          input logic [15:0] color, input logic [23:0] exp_data,
                          input logic hold, input int abort_c, input string name);
    int x1c, y1c, w, h, k_total, done_c, k;
    logic exp_w;
    x1c = (x1 > 95) ? 95 : x1;
    y1c = (y1 > 63) ? 63 : y1;
    w = 1;
    k_total = 0;
    if (!(x0 > x1c || y0 > y1c)) begin
      w = x1c - x0 + 1;
      h = y1c - y0 + 1;
      k_total = w * h;
    end
    done_c = (k_total == 0) ? 1 : 2 + (k_total - 1) * pace;

    @(negedge CLK);
    sel = use3;
    #1;
    check_eq({name, " ready before"}, {31'd0, o_ready}, 32'd1);
    req_color = color;
    req_x0 = 7'(x0); req_x1 = 7'(x1);
    req_y0 = 6'(y0); req_y1 = 6'(y1);
    req_valid = 1'b1;
    @(posedge CLK); #1;
    if (!hold) req_valid = 1'b0;

    for (int c = 1; c <= done_c + 1; c++) begin
      k = (c - 1) / pace;
      exp_w = ((c - 1) % pace == 0) && (k < k_total);
      check_eq($sformatf("%s write c%0d", name, c), {31'd0, o_write}, {31'd0, exp_w});
      if (k_total > 0) begin
        if (k > k_total - 1) k = k_total - 1;
        check_eq($sformatf("%s col c%0d", name, c), {25'd0, o_col}, 32'(x0 + k % w));
        check_eq($sformatf("%s row c%0d", name, c), {26'd0, o_row}, 32'(y0 + k / w));
        check_eq($sformatf("%s data c%0d", name, c), {8'd0, o_data}, {8'd0, exp_data});
      end
      check_eq($sformatf("%s done c%0d", name, c),  {31'd0, o_done},  {31'd0, (c == done_c)});
      check_eq($sformatf("%s busy c%0d", name, c),  {31'd0, o_busy},  {31'd0, (c <= done_c)});
      check_eq($sformatf("%s ready c%0d", name, c), {31'd0, o_ready}, {31'd0, (c > done_c)});
      if (hold) begin
        req_color = ~req_color;
        req_x0 = 7'd0; req_y0 = 6'd0;
        if (c == done_c + 1) req_valid = 1'b0;
      end
      if (c == abort_c) begin
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs({name, " abort"});
        RESET = 1'b0;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        check_eq({name, " ready after abort"}, {31'd0, o_ready}, 32'd1);
        check_eq({name, " no done after abort"}, {31'd0, o_done}, 32'd0);
        return;
      end
      if (c <= done_c) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_color = 16'h0000;
    req_x0 = 7'd0; req_x1 = 7'd0;
    req_y0 = 6'd0; req_y1 = 6'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset p1");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset p3");
    sel = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check_eq("ready after reset", {31'd0, o_ready}, 32'd1);

    // Full screen red, with req_* scrambled and valid held during the fill.
    run_fill(1'b0, 1, 0, 95, 0, 63, 16'hF800, 24'hFF0000, 1'b1, 0, "full");
    // Single green pixel, accepted back-to-back with the previous completion.
    run_fill(1'b0, 1, 10, 10, 5, 5, 16'h07E0, 24'h00FF00, 1'b0, 0, "single");
    // Expansion and pacing on the PACE=3 instance.
    run_fill(1'b1, 3, 2, 3, 1, 2, 16'h8410, 24'h848284, 1'b0, 0, "pace3");
    // Clamped right edge: columns 90..95 on rows 62 and 63.
    run_fill(1'b0, 1, 90, 127, 62, 63, 16'hFFFF, 24'hFFFFFF, 1'b0, 0, "clamp");
    // Empty rectangle: no writes, done in cycle 1.
    run_fill(1'b0, 1, 20, 10, 0, 0, 16'h1234, 24'hFFFFFF, 1'b0, 0, "empty");
    // Reset in cycle 100 of a full-screen fill, then a fresh fill.
    run_fill(1'b0, 1, 0, 95, 0, 63, 16'hF800, 24'hFF0000, 1'b0, 100, "abort");
    run_fill(1'b0, 1, 5, 7, 3, 4, 16'h001F, 24'h0000FF, 1'b0, 0, "after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_rect_fill.md
# oled_rect_fill

Rectangle-fill engine sitting downstream of the push-button colour selector. It takes the current RGB565 colour and a pixel rectangle through a valid/ready request, expands the colour to RGB888, and streams one OLED pixel write per pixel in row-major order. It drives the Wrapper-level OLED_Write / OLED_Col / OLED_Row / OLED_Data port directly.

## Interface
- COLS, 96, display width in pixels; legal range 1..128.
- ROWS, 64, display height in pixels; legal range 1..64.
- PACE, 1, cycles between consecutive pixel writes; legal range ≥1.

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  reset; synchronous, active-high.
- req_valid  in  1  fill request present.
- req_ready  out  1  engine idle and able to accept; reset value 0, then 1 from the first cycle after RESET deasserts.
- req_color  in  16  RGB565: [15:11] R, [10:5] G, [4:0] B.
- req_x0, req_x1  in  7  inclusive column bounds.
- req_y0, req_y1  in  6  inclusive row bounds.
- OLED_Write  out  1  one-cycle pixel write strobe; reset 0.
- OLED_Col  out  7  pixel column; reset 0.
- OLED_Row  out  6  pixel row; reset 0.
- OLED_Data  out  24  RGB888 {R8,G8,B8}; reset 0.
- busy  out  1  high in FILL and DONE states; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - req_ready=1.
  - req_valid && req_ready at a rising edge accepts the request.
  - On acceptance, latch the colour and the clamped bounds.
  - Go to FILL. If the rectangle is empty, go to DONE instead.
- Clamping: x1c = min(req_x1, COLS-1) and y1c = min(req_y1, ROWS-1).
- Empty rectangle: req_x0 > x1c or req_y0 > y1c. No pixel writes are issued.
- Colour expansion:
  - R8 = {R5, R5[4:2]}.
  - G8 = {G6, G6[5:4]}.
  - B8 = {B5, B5[4:2]}.
- FILL:
  - Scan starts at (x0, y0).
  - Column increments first. On reaching x1c, column wraps to x0 and row increments.
  - Pixel (x1c, y1c) is the last write; then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Inputs are sampled only at acceptance. Changes to req_* during a fill have no effect.
- req_valid while busy is ignored; req_ready=0. There is no queueing.
- OLED_Col, OLED_Row and OLED_Data hold their last values between strobes and after completion.
- RESET at any time, including mid-fill:
  - Abort immediately.
  - All outputs go to their reset values.
  - No done pulse is issued for the aborted fill.

## Timing
- Cycle 0 is the cycle in which acceptance occurs; cycle n is n cycles later.
- Pixel count K = (x1c-x0+1)·(y1c-y0+1).
- Write k (k = 0..K-1) has OLED_Write high in cycle 1+k·PACE. Col, Row and Data are valid in that same cycle.
- OLED_Write is low in all other cycles. With PACE=1, writes are back-to-back.
- done is high in cycle 2+(K-1)·PACE.
- req_ready returns high in the following cycle. A new request can be accepted in that cycle.
- Empty rectangle: done is high in cycle 1, and req_ready is high in cycle 2.
- busy is high from cycle 1 through the done cycle inclusive.

## Test plan
- Full screen, PACE=1:
  - Stimulus: colour 0xF800, rectangle (0,0)-(95,63).
  - Required: 6144 consecutive strobes, Data=0xFF0000.
  - First write at (0,0) in cycle 1; last write at (95,63) in cycle 6144.
  - done in cycle 6145; req_ready in cycle 6146.
- Single pixel:
  - Stimulus: colour 0x07E0 at (10,5)-(10,5).
  - Required: exactly one strobe in cycle 1, Col=10, Row=5, Data=0x00FF00; done in cycle 2.
- Expansion and pacing, PACE=3:
  - Stimulus: colour 0x8410, rectangle (2,1)-(3,2).
  - Required: Data=0x848284.
  - Write order (2,1),(3,1),(2,2),(3,2) in cycles 1,4,7,10; done in cycle 11.
- Clamping and empty rectangle:
  - (90,62)-(127,63) gives 12 writes, with columns 90..95 on rows 62 then 63.
  - (20,0)-(10,0) gives zero writes and done in cycle 1.
- Busy and latching:
  - Stimulus: change req_color and hold req_valid high during a full-screen fill.
  - Required: Data never changes; req_ready stays 0; no second fill starts until req_ready returns.
- Reset mid-fill:
  - Stimulus: assert RESET in cycle 100 of a full-screen fill.
  - Required: next cycle all outputs are 0 and there is no done pulse.
  - After RESET deasserts, req_ready=1 and a new request fills correctly from its own (x0,y0).
